// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// stall-cycle counter. Stalls and flushes both insert a bubble into EX.
module id_ex_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_ID,
  input  logic [4:0]   rs_ID,
  input  logic [4:0]   rt_ID,
  input  logic [4:0]   rw_ID,
  input  logic         rt_used_ID,
  input  logic [W-1:0] busA_ID,
  input  logic [W-1:0] busB_ID,
  input  logic [W-1:0] imm_ID,
  input  logic         RegWr_ID,
  input  logic         MemRead_ID,
  input  logic         MemWr_ID,
  input  logic         ALUSrc_ID,
  input  logic [3:0]   ALUctr_ID,
  input  logic         flush,
  output logic [4:0]   rs_EX,
  output logic [4:0]   rt_EX,
  output logic [4:0]   rw_EX,
  output logic [W-1:0] busA_EX,
  output logic [W-1:0] busB_EX,
  output logic [W-1:0] imm_EX,
  output logic         RegWr_EX,
  output logic         MemRead_EX,
  output logic         MemWr_EX,
  output logic         ALUSrc_EX,
  output logic         valid_EX,
  output logic [3:0]   ALUctr_EX,
  output logic         stall,
  output logic [15:0]  stall_cnt
);

  typedef struct packed {
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rw;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic [W-1:0] imm;
    logic         regwr;
    logic         memrd;
    logic         memwr;
    logic         alusrc;
    logic         valid;
    logic [3:0]   aluctr;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        src_hit;
  logic        kill;

  // Only a valid load in EX with a nonzero destination can block ID.
  assign src_hit = (ex_q.rw == rs_ID) | (rt_used_ID & (ex_q.rw == rt_ID));
  assign stall   = valid_ID & ex_q.valid & ex_q.memrd & (ex_q.rw != 5'd0) & src_hit;
  assign kill    = flush | stall | ~valid_ID;

  always_comb begin
    ex_d        = '0;
    ex_d.rs     = rs_ID;
    ex_d.rt     = rt_ID;
    ex_d.busA   = busA_ID;
    ex_d.busB   = busB_ID;
    ex_d.imm    = imm_ID;
    ex_d.alusrc = ALUSrc_ID;
    ex_d.aluctr = ALUctr_ID;
    // Bubble: side-effecting control and destination cleared; data passes through.
    ex_d.rw     = kill ? 5'd0 : rw_ID;
    ex_d.regwr  = ~kill & RegWr_ID;
    ex_d.memrd  = ~kill & MemRead_ID;
    ex_d.memwr  = ~kill & MemWr_ID;
    ex_d.valid  = ~kill;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rs_EX      = ex_q.rs;
  assign rt_EX      = ex_q.rt;
  assign rw_EX      = ex_q.rw;
  assign busA_EX    = ex_q.busA;
  assign busB_EX    = ex_q.busB;
  assign imm_EX     = ex_q.imm;
  assign RegWr_EX   = ex_q.regwr;
  assign MemRead_EX = ex_q.memrd;
  assign MemWr_EX   = ex_q.memwr;
  assign ALUSrc_EX  = ex_q.alusrc;
  assign valid_EX   = ex_q.valid;
  assign ALUctr_EX  = ex_q.aluctr;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: W, 32, width of operand/immediate data paths.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_ID  input  1  ID stage holds a real instruction.
REQ-005 rs_ID, rt_ID, rw_ID  input  5 each  source and destination register numbers decoded in ID.
REQ-006 rt_used_ID  input  1  instruction reads rt as a source (R-type, store, beq).
REQ-007 busA_ID, busB_ID, imm_ID  input  W each  register-file reads and extended immediate.
REQ-008 RegWr_ID, MemRead_ID, MemWr_ID, ALUSrc_ID  input  1 each  decoded control.
REQ-009 ALUctr_ID  input  4  decoded ALU operation.
REQ-010 flush  input  1  branch/jump taken in EX; squash the instruction entering EX.
REQ-011 rs_EX, rt_EX, rw_EX  output  5 each  registered register numbers for EX forwarding.
REQ-012 busA_EX, busB_EX, imm_EX  output  W each  registered data.
REQ-013 RegWr_EX, MemRead_EX, MemWr_EX, ALUSrc_EX, valid_EX  output  1 each  registered control.
REQ-014 ALUctr_EX  output  4  registered ALU operation.
REQ-015 stall  output  1  combinational load-use hazard; PC and IF/ID hold when high.
REQ-016 stall_cnt  output  16  saturating count of stall cycles since reset.

Function
REQ-017 stall SHALL be 1 iff valid_ID & valid_EX & MemRead_EX & rw_EX!=0 & (rw_EX==rs_ID | (rt_used_ID & rw_EX==rt_ID)); else 0.
REQ-018 Register-0 destination SHALL never cause stall.
REQ-019 EX register SHALL update every rising clk edge; no hold/enable state exists.
REQ-020 Priority per edge: flush, then stall, then normal load.
REQ-021 Flush: valid_EX, RegWr_EX, MemRead_EX, MemWr_EX SHALL load 0, rw_EX SHALL load 0; other fields load ID values.
REQ-022 Stall (flush=0): bubble identical to flush load (control 0, rw_EX=0, valid_EX=0); data fields load ID values.
REQ-023 Normal load: every EX output SHALL load its _ID counterpart; valid_ID=0 SHALL also zero RegWr/MemRead/MemWr/rw in EX.
REQ-024 Latency: ID inputs appear on EX outputs exactly 1 cycle later; a stalled instruction reaches EX one cycle after stall deasserts.
REQ-025 A bubble SHALL clear MemRead_EX, so stall self-deasserts the next cycle (never more than 1 consecutive cycle per load).
REQ-026 stall_cnt SHALL increment by 1 on each edge where stall=1 and flush=0; holds at 16'hFFFF (no wrap).
REQ-027 Simultaneous flush and stall: flush wins, stall_cnt not incremented; stall output itself still reflects REQ-017.

Reset
REQ-028 rst_n=0 SHALL immediately (no clock) force all registered outputs and stall_cnt to 0.
REQ-029 With all EX outputs 0, stall SHALL read 0 during and after reset.
REQ-030 Reset deasserted mid-stream: first edge after release SHALL perform a normal load.

Verification
REQ-031 Load-use: EX holds lw rw_EX=8 (MemRead_EX=1, valid_EX=1); ID add rs_ID=8 -> stall=1, next edge valid_EX=0, RegWr_EX=0, stall=0, stall_cnt=1; following edge add appears with rs_EX=8.
REQ-032 rt path: lw rw_EX=9; ID sub rt_ID=9, rt_used_ID=1 -> stall=1; same with rt_used_ID=0 -> stall=0.
REQ-033 Zero register: lw rw_EX=0, ID rs_ID=0 -> stall=0, normal load.
REQ-034 Flush vs stall: load-use condition plus flush=1 -> stall=1, next edge bubble in EX, stall_cnt unchanged.
REQ-035 Saturation: force 65,536 stall edges -> stall_cnt=16'hFFFF, stays after further stalls.
REQ-036 Async reset: assert rst_n=0 between edges with valid_EX=1, busA_EX=32'h1234 -> outputs 0 immediately; release, next edge loads ID values.
